// File: rtl/fifo_pkg.sv
// Shared constants and request-decode helpers for the FIFO address/flag controller.
// Storage lives outside this block; only pointers and occupancy flags are kept here.
package fifo_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    // Encoded as {write_accepted, read_accepted}
    typedef enum logic [1:0] {
        OpIdle  = 2'b00,
        OpRead  = 2'b01,
        OpWrite = 2'b10,
        OpBoth  = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e decode_op(input logic wr_ok, input logic rd_ok);
        return fifo_op_e'({wr_ok, rd_ok});
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer: enable-gated counter modulo 2**WIDTH with synchronous clear.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = fifo_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] addr
);

    logic [WIDTH-1:0] addr_q;

    // Natural binary overflow gives the modulo-depth wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (en) begin
            addr_q <= addr_q + WIDTH'(1);
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/fifo.sv
// FIFO address/flag controller: hands out write/read slots for external storage and
// tracks occupancy with registered full/empty flags.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] r_addr
);

    localparam int unsigned       Depth     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(Depth);

    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            wr_ok, rd_ok;
    fifo_op_e        op;

    // Requests are qualified by the flags as registered before this edge
    assign wr_ok = wr & ~full_q;
    assign rd_ok = rd & ~empty_q;
    assign op    = decode_op(wr_ok, rd_ok);

    always_comb begin
        count_d = count_q;
        unique case (op)
            OpWrite: count_d = count_q + (ADDR_W + 1)'(1);
            OpRead:  count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FullCount);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    fifo_ptr #(
        .WIDTH(ADDR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_ok),
        .addr(w_addr)
    );

    fifo_ptr #(
        .WIDTH(ADDR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_ok),
        .addr(r_addr)
    );

    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_fifo.sv
// Bench for the FIFO controller: occupancy-level model checked every cycle, plus
// literal checkpoints along a directed fill/drain/overflow/underflow/reset sequence.
module tb_fifo;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic       full;
    logic       empty;
    logic [2:0] w_addr;
    logic [2:0] r_addr;

    int checks = 0;
    int errors = 0;

    // Model state: occupancy and pointers as plain integers
    int m_occ   = 0;
    int m_wp    = 0;
    int m_rp    = 0;
    bit m_valid = 0;

    fifo #(
        .ADDR_W(3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .rd    (rd),
        .full  (full),
        .empty (empty),
        .w_addr(w_addr),
        .r_addr(r_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_occ   = 0;
            m_wp    = 0;
            m_rp    = 0;
            m_valid = 1;
        end else if (m_valid) begin
            int w;
            int r;
            w = (wr === 1'b1 && m_occ < 8) ? 1 : 0;
            r = (rd === 1'b1 && m_occ > 0) ? 1 : 0;
            m_occ = m_occ + w - r;
            m_wp  = (m_wp + w) % 8;
            m_rp  = (m_rp + r) % 8;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_full", {7'd0, full}, (m_occ == 8) ? 8'd1 : 8'd0);
            check("model_empty", {7'd0, empty}, (m_occ == 0) ? 8'd1 : 8'd0);
            check("model_w_addr", {5'd0, w_addr}, 8'(m_wp));
            check("model_r_addr", {5'd0, r_addr}, 8'(m_rp));
        end
    end

    task automatic tick(input logic r, input logic w, input logic d);
        rst = r;
        wr  = w;
        rd  = d;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_state(input string tag, input logic [2:0] ew, input logic [2:0] er,
                                input logic ee, input logic ef);
        check({tag, "_w_addr"}, {5'd0, w_addr}, {5'd0, ew});
        check({tag, "_r_addr"}, {5'd0, r_addr}, {5'd0, er});
        check({tag, "_empty"}, {7'd0, empty}, {7'd0, ee});
        check({tag, "_full"}, {7'd0, full}, {7'd0, ef});
    endtask

    initial begin
        rst = 1'b1;
        wr  = 1'b1;
        rd  = 1'b0;

        // Reset with a write pending
        tick(1'b1, 1'b1, 1'b0);
        expect_state("reset", 3'd0, 3'd0, 1'b1, 1'b0);

        // Partial fill and drain
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1);
        expect_state("partial", 3'd4, 3'd2, 1'b0, 1'b0);

        // Overflow: full after the 6th write, remaining writes ignored
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (i == 4) expect_state("ovf_pre", 3'd1, 3'd2, 1'b0, 1'b0);
            if (i == 5) expect_state("ovf_full", 3'd2, 3'd2, 1'b0, 1'b1);
        end
        expect_state("ovf_hold", 3'd2, 3'd2, 1'b0, 1'b1);

        // Underflow: empty after the 8th read, remaining reads ignored
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (i == 7) expect_state("udf_empty", 3'd2, 3'd2, 1'b1, 1'b0);
        end
        expect_state("udf_hold", 3'd2, 3'd2, 1'b1, 1'b0);

        // Simultaneous while empty: write only
        tick(1'b0, 1'b1, 1'b1);
        expect_state("both_empty", 3'd3, 3'd2, 1'b0, 1'b0);

        // Bring occupancy to 3, then simultaneous: both advance, occupancy kept
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        expect_state("both_mid", 3'd6, 3'd3, 1'b0, 1'b0);

        // Fill to 8, then simultaneous while full: read only
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
        expect_state("refill", 3'd3, 3'd3, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        expect_state("both_full", 3'd3, 3'd4, 1'b0, 1'b0);

        // Refill, then reset while full with both requests active
        tick(1'b0, 1'b1, 1'b0);
        expect_state("full_again", 3'd4, 3'd4, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        expect_state("reset_full", 3'd0, 3'd0, 1'b1, 1'b0);

        // Light traffic after reset
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        expect_state("post_reset", 3'd2, 3'd2, 1'b1, 1'b0);

        tick(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
